data_mem_responder: RTL and testbench

- Memory-side responder for the core's load/store port.
- Accepts one request at a time through a valid/ready handshake and models a configurable access latency.
- Performs RV32I byte, half and word accesses with byte-lane steering and sign/zero extension, then returns a response through a second valid/ready handshake.
- Replaces the single-cycle combinational data memory in the datapath's MEM stage; the core stalls on req_ready/rsp_valid.

---
 rtl/riscv_mem_pkg.sv | 28 ++
 rtl/mem_lane_unit.sv | 89 ++++++++
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 tb/tb_data_mem_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM state
// encoding and the alignment check used by the lane unit.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Only funct3[1:0] decides the access size, so BU/HU share the B/H checks.
  function automatic logic misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
    logic mis;
    case (func3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational byte-lane steering for RV32I loads and stores: builds byte
// enables and the replicated write word, extracts and extends load data.
module mem_lane_unit
  import riscv_mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        err
);

  logic        illegal_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Legality of the funct3 code for this direction.
  always_comb begin
    illegal_s = 1'b0;
    case (func3)
      F3_B, F3_H, F3_W: illegal_s = 1'b0;
      F3_BU, F3_HU:     illegal_s = we;
      default:          illegal_s = 1'b1;
    endcase
  end

  assign err = illegal_s | misaligned(func3, addr_lo);

  // Select the addressed byte and half from the stored word.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'd0:    byte_s = rword[7:0];
      2'd1:    byte_s = rword[15:8];
      2'd2:    byte_s = rword[23:16];
      2'd3:    byte_s = rword[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = rword[31:16];
    end else begin
      half_s = rword[15:0];
    end
  end

  // Errors and stores return zero data; erroring stores enable no lanes.
  always_comb begin
    be    = 4'b0000;
    wword = 32'h0000_0000;
    rdata = 32'h0000_0000;
    if (err) begin
      be    = 4'b0000;
      rdata = 32'h0000_0000;
    end else if (we) begin
      case (func3)
        F3_B: begin
          be    = 4'b0001 << addr_lo;
          wword = {4{wdata[7:0]}};
        end
        F3_H: begin
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wword = {2{wdata[15:0]}};
        end
        F3_W: begin
          be    = 4'b1111;
          wword = wdata;
        end
        default: begin
          be    = 4'b0000;
          wword = 32'h0000_0000;
        end
      endcase
    end else begin
      case (func3)
        F3_B:    rdata = {{24{byte_s[7]}}, byte_s};
        F3_BU:   rdata = {24'h000000, byte_s};
        F3_H:    rdata = {{16{half_s[15]}}, half_s};
        F3_HU:   rdata = {16'h0000, half_s};
        F3_W:    rdata = rword;
        default: rdata = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Latency-modelling data memory for the core's load/store port: one request
// in flight, access performed at the end of the wait, response held until taken.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t          state_r;
  state_t          state_nxt;
  logic [CW-1:0]   cnt_r;
  logic            we_r;
  logic [2:0]      func3_r;
  logic [AW+1:0]   addr_r;
  logic [31:0]     wdata_r;
  logic [31:0]     rdata_r;
  logic            err_r;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept_s;
  logic            commit_s;
  logic [AW-1:0]   idx_s;
  logic [31:0]     rword_s;
  logic [3:0]      be_s;
  logic [31:0]     wword_s;
  logic [31:0]     lane_rdata_s;
  logic            lane_err_s;
  logic            unused_addr_s;

  // Upper address bits only alias the array, so they are dropped at the latch.
  assign unused_addr_s = ^req_addr[31:AW+2];

  assign req_ready = (state_r == ST_IDLE) && !rst;
  assign rsp_valid = (state_r == ST_RESP) && !rst;
  assign rsp_rdata = rst ? 32'h0000_0000 : rdata_r;
  assign rsp_err   = rst ? 1'b0 : err_r;

  assign accept_s = req_valid && (state_r == ST_IDLE);
  assign commit_s = (state_r == ST_WAIT) && (cnt_r == {CW{1'b0}});
  assign idx_s    = addr_r[AW+1:2];
  assign rword_s  = mem[idx_s];

  mem_lane_unit u_lane (
    .we      (we_r),
    .func3   (func3_r),
    .addr_lo (addr_r[1:0]),
    .wdata   (wdata_r),
    .rword   (rword_s),
    .be      (be_s),
    .wword   (wword_s),
    .rdata   (lane_rdata_s),
    .err     (lane_err_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_nxt = ST_RESP;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RESP;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, latency counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CW{1'b0}};
      we_r    <= 1'b0;
      func3_r <= 3'b000;
      addr_r  <= {(AW+2){1'b0}};
      wdata_r <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else if (accept_s) begin
      cnt_r   <= CW'(LATENCY - 1);
      we_r    <= req_we;
      func3_r <= req_func3;
      addr_r  <= req_addr[AW+1:0];
      wdata_r <= req_wdata;
    end else if (commit_s) begin
      rdata_r <= lane_rdata_s;
      err_r   <= lane_err_s;
    end else if (state_r == ST_WAIT) begin
      cnt_r <= cnt_r - CW'(1);
    end else if ((state_r == ST_RESP) && rsp_ready) begin
      rdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Store commit; the array has no reset and only changes on the WAIT->RESP edge.
  always_ff @(posedge clk) begin
    if (!rst && commit_s && we_r) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[idx_s][8*i +: 8] <= wword_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: scoreboarded load/store sequence with
// latency, extension, error, abort, backpressure and wrap checks.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full request/response; hold>0 keeps rsp_ready low that many cycles.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_d, input logic exp_e, input int hold);
    bit   got;
    int   lat;
    exp_t e;
    sb.push_back('{rdata: exp_d, err: exp_e});
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = (hold == 0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_accept"}, {31'd0, got}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    chk({tag, "_rspvalid"}, {31'd0, got}, 32'd1);
    chk({tag, "_latency"}, lat, LAT);
    e = sb.pop_front();
    chk({tag, "_rdata"}, rsp_rdata, e.rdata);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
      chk({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_func3 = 3'b000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    // Prior content, then a store aborted by reset while waiting.
    do_req("sw_prior", 1'b1, 3'b010, 32'h10, 32'h0BAD_F00D, 32'h0, 1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_func3 = 3'b010;
    req_addr  = 32'h10;
    req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_ready", {31'd0, req_ready}, 32'd0);
      chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
      chk("abort_rdata", rsp_rdata, 32'h0);
    end
    rst = 1'b0;
    do_req("lw_after_abort", 1'b0, 3'b010, 32'h10, 32'h0, 32'h0BAD_F00D, 1'b0, 0);

    do_req("sw0", 1'b1, 3'b010, 32'h0, 32'h1234_5678, 32'h0, 1'b0, 0);
    do_req("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 32'h1234_5678, 1'b0, 0);
    do_req("lb3", 1'b0, 3'b000, 32'h3, 32'h0, 32'h0000_0012, 1'b0, 0);
    do_req("lbu0", 1'b0, 3'b100, 32'h0, 32'h0, 32'h0000_0078, 1'b0, 0);
    do_req("sw4", 1'b1, 3'b010, 32'h4, 32'h80FF_8001, 32'h0, 1'b0, 0);
    do_req("lh6", 1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF_80FF, 1'b0, 0);
    do_req("lhu4", 1'b0, 3'b101, 32'h4, 32'h0, 32'h0000_8001, 1'b0, 0);
    do_req("lb4", 1'b0, 3'b000, 32'h4, 32'h0, 32'h0000_0001, 1'b0, 0);
    do_req("lb5", 1'b0, 3'b000, 32'h5, 32'h0, 32'hFFFF_FF80, 1'b0, 0);
    do_req("lbu7", 1'b0, 3'b100, 32'h7, 32'h0, 32'h0000_0080, 1'b0, 0);
    do_req("lh4", 1'b0, 3'b001, 32'h4, 32'h0, 32'hFFFF_8001, 1'b0, 0);

    // Partial stores with junk in unused wdata bits.
    do_req("sb1", 1'b1, 3'b000, 32'h1, 32'h1234_56AA, 32'h0, 1'b0, 0);
    do_req("sh2", 1'b1, 3'b001, 32'h2, 32'h5555_BEEF, 32'h0, 1'b0, 0);
    do_req("lw_merge", 1'b0, 3'b010, 32'h0, 32'h0, 32'hBEEF_AA78, 1'b0, 0);

    // Errors must not disturb the array.
    do_req("lw2_err", 1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 1'b1, 0);
    do_req("sh1_err", 1'b1, 3'b001, 32'h1, 32'h0000_1111, 32'h0, 1'b1, 0);
    do_req("f3_011_err", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 0);
    do_req("sbu_err", 1'b1, 3'b100, 32'h0, 32'h0000_0033, 32'h0, 1'b1, 0);
    do_req("sw2_err", 1'b1, 3'b010, 32'h2, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    do_req("lw_unchanged", 1'b0, 3'b010, 32'h0, 32'h0, 32'hBEEF_AA78, 1'b0, 0);

    do_req("lw_stall", 1'b0, 3'b010, 32'h0, 32'h0, 32'hBEEF_AA78, 1'b0, 5);

    do_req("sw_wrap", 1'b1, 3'b010, 32'h1000, 32'h0000_0055, 32'h0, 1'b0, 0);
    do_req("lw_wrap", 1'b0, 3'b010, 32'h0, 32'h0, 32'h0000_0055, 1'b0, 0);
    do_req("lw_wrap_hi", 1'b0, 3'b010, 32'hFFFF_F010, 32'h0, 32'h0BAD_F00D, 1'b0, 0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
